// File: rtl/rx_setting_sched_if.sv
// Setting-change request channel: valid/ready handshake carrying the requested rx_setting code.
interface rx_setting_sched_if #(
  parameter int SETTING_WIDTH = 4
) ();
  logic                     req_valid;
  logic [SETTING_WIDTH-1:0] req_setting;
  logic                     req_ready;

  modport master (output req_valid, output req_setting, input req_ready);
  modport slave  (input req_valid, input req_setting, output req_ready);
endinterface

// File: rtl/rx_setting_sched.sv
// Applies rx_setting changes one cycle after a filter time event, then blanks settled for FLUSH_EVENTS events.
// Latency: accept -> apply at first later event + 1 cycle; req_ready low only while a change waits for its event.
module rx_setting_sched #(
  parameter int SETTING_WIDTH = 4,
  parameter int NUM_SETTINGS  = 16,
  parameter int FLUSH_EVENTS  = 8,
  parameter int RESET_SETTING = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     time_eq_in,
  rx_setting_sched_if.slave        req,
  output logic [SETTING_WIDTH-1:0] rx_setting,
  output logic                     apply_pulse,
  output logic                     settled,
  output logic                     busy,
  output logic                     err_invalid
);

  localparam int                     CNT_W    = $clog2(FLUSH_EVENTS + 1);
  localparam logic [CNT_W-1:0]         CNT_INIT = CNT_W'(FLUSH_EVENTS);
  localparam logic [SETTING_WIDTH-1:0] RST_SET  = SETTING_WIDTH'(RESET_SETTING);
  localparam logic [31:0]              NUM_U    = 32'(NUM_SETTINGS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    FLUSH     = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SETTING_WIDTH-1:0] rx_setting_q, rx_setting_d;
  logic [SETTING_WIDTH-1:0] pending_q, pending_d;
  logic                     settled_q, settled_d;
  logic                     apply_q, apply_d;
  logic                     err_q, err_d;

  logic req_ready_w;
  logic code_ok;
  logic accept;

  assign req_ready_w   = (state_q != WAIT_EDGE);
  assign req.req_ready = req_ready_w;
  assign busy          = (state_q != IDLE);
  assign code_ok       = (32'(req.req_setting) < NUM_U);
  assign accept        = req.req_valid && req_ready_w && code_ok;

  assign rx_setting  = rx_setting_q;
  assign apply_pulse = apply_q;
  assign settled     = settled_q;
  assign err_invalid = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FLUSH;
      cnt_q        <= CNT_INIT;
      rx_setting_q <= RST_SET;
      pending_q    <= RST_SET;
      settled_q    <= 1'b0;
      apply_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rx_setting_q <= rx_setting_d;
      pending_q    <= pending_d;
      settled_q    <= settled_d;
      apply_q      <= apply_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rx_setting_d = rx_setting_q;
    pending_d    = pending_q;
    apply_d      = 1'b0;
    err_d        = req.req_valid && req_ready_w && !code_ok;

    unique case (state_q)
      IDLE: begin
        // A request for the setting already in force completes the handshake but changes nothing.
        if (accept && (req.req_setting != rx_setting_q)) begin
          pending_d = req.req_setting;
          state_d   = WAIT_EDGE;
        end
      end
      WAIT_EDGE: begin
        if (time_eq_in) begin
          rx_setting_d = pending_q;
          apply_d      = 1'b1;
          cnt_d        = CNT_INIT;
          state_d      = FLUSH;
        end
      end
      FLUSH: begin
        // A new accept outranks a coincident event; the remaining flush count is abandoned.
        if (accept) begin
          pending_d = req.req_setting;
          state_d   = WAIT_EDGE;
        end else if (time_eq_in) begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = FLUSH;
        cnt_d   = CNT_INIT;
      end
    endcase

    settled_d = (state_d == IDLE);
  end

  apply_only_after_event: assert property (@(posedge clk) disable iff (!rst)
    apply_q |-> $past((state_q == WAIT_EDGE) && time_eq_in));

  err_only_after_bad_req: assert property (@(posedge clk) disable iff (!rst)
    err_q |-> $past(req.req_valid && req_ready_w && !code_ok));

  settled_matches_idle: assert property (@(posedge clk) disable iff (!rst)
    settled_q == (state_q == IDLE));

endmodule
